// File: rtl/itr_ctrl.sv
// -----------------------------------------------------------------------------
// itr_ctrl
//
// Sequences the core's single interrupt input. Rising edges on up to NSRC
// event lines are latched as pending bits. The lowest-numbered pending,
// unmasked source wins when the global enable is set. The controller waits
// HOLDOFF cycles in ARM, issues a one-cycle itr pulse, and then holds off
// further requests until the service routine pulses iret.
//
// Optional build macro:
//   ITR_SYNC_EN  when defined, each src_in bit passes through a two-flop
//                synchronizer before edge detection (+2 cycles latency), so
//                the sources may be asynchronous to clk. When undefined,
//                src_in must be synchronous to clk.
//
// Ports:
//   clk       system clock
//   rst       synchronous, active-low reset
//   src_in    [NSRC]    event lines, rising edge requests an interrupt
//   io_wr     register write strobe (decoded core out_en)
//   io_rd     register read strobe (decoded core req_in)
//   io_addr   [2]       register select: 0 MASK, 1 PEND, 2 ID, 3 CTRL
//   io_wdata  [NUBITS]  write data
//   io_rdata  [NUBITS]  registered read data
//   iret      one-cycle pulse, service routine finished
//   itr       one-cycle interrupt pulse to the core
//   busy      high from FIRE through SERVICE
//   id        index of the source being serviced
//
// Register port protocol: io_wr and io_rd are single-cycle strobes with no
// back-pressure. A write lands on the clock edge where io_wr is high. A read
// samples the selected register on the edge where io_rd is high; io_rdata
// then holds that value until the next read.
// -----------------------------------------------------------------------------
module itr_ctrl #(
  parameter int NSRC    = 4,
  parameter int NUBITS  = 32,
  parameter int HOLDOFF = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NSRC-1:0]                       src_in,
  input  logic                                  io_wr,
  input  logic                                  io_rd,
  input  logic [1:0]                            io_addr,
  input  logic [NUBITS-1:0]                     io_wdata,
  output logic [NUBITS-1:0]                     io_rdata,
  input  logic                                  iret,
  output logic                                  itr,
  output logic                                  busy,
  output logic [((NSRC > 1) ? $clog2(NSRC) : 1)-1:0] id
);

  localparam int IDW = (NSRC > 1) ? $clog2(NSRC) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARM     = 2'd1,
    S_FIRE    = 2'd2,
    S_SERVICE = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [3:0]        cnt;
  logic [3:0]        cnt_nxt;
  logic [IDW-1:0]    id_nxt;

  logic [NSRC-1:0]   src;
  logic [NSRC-1:0]   src_q;
  logic [NSRC-1:0]   src_rise;
  logic [NSRC-1:0]   mask;
  logic [NSRC-1:0]   pend;
  logic [NSRC-1:0]   pend_nxt;
  logic [NSRC-1:0]   elig;
  logic              en;
  logic              any_elig;
  logic [IDW-1:0]    winner;
  logic [NUBITS-1:0] rd_mux;

  logic              wr_mask;
  logic              wr_pend;
  logic              wr_ctrl;

  // Only the low NSRC bits (and bit 0 for CTRL) of the write bus matter.
  logic              unused_wdata;
  assign unused_wdata = ^io_wdata;

  // ---------------------------------------------------------------------------
  // Source conditioning
  // ---------------------------------------------------------------------------
`ifdef ITR_SYNC_EN
  logic [NSRC-1:0] sync1;
  logic [NSRC-1:0] sync2;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= src_in;
      sync2 <= sync1;
    end
  end

  assign src = sync2;
`else
  assign src = src_in;
`endif

  assign src_rise = src & ~src_q;

  // ---------------------------------------------------------------------------
  // Register decode and arbitration
  // ---------------------------------------------------------------------------
  assign wr_mask = io_wr && (io_addr == 2'd0);
  assign wr_pend = io_wr && (io_addr == 2'd1);
  assign wr_ctrl = io_wr && (io_addr == 2'd3);

  assign elig     = en ? (pend & mask) : '0;
  assign any_elig = |elig;

  // Scan from the top down so the lowest eligible index is the final winner.
  always_comb begin
    winner = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (elig[i]) begin
        winner = IDW'(i);
      end
    end
  end

  // Order matters: write-1-clear, then the serviced-bit clear at the end of
  // FIRE, then new edges last so a same-cycle edge always wins.
  always_comb begin
    pend_nxt = pend;
    if (wr_pend) begin
      pend_nxt = pend_nxt & ~io_wdata[NSRC-1:0];
    end
    if (state == S_FIRE) begin
      pend_nxt[id] = 1'b0;
    end
    pend_nxt = pend_nxt | src_rise;
  end

  always_comb begin
    rd_mux = '0;
    case (io_addr)
      2'd0:    rd_mux[NSRC-1:0] = mask;
      2'd1:    rd_mux[NSRC-1:0] = pend;
      2'd2:    rd_mux[IDW-1:0]  = id;
      default: rd_mux[0]        = en;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      src_q    <= '0;
      mask     <= '0;
      pend     <= '0;
      en       <= 1'b0;
      io_rdata <= '0;
    end else begin
      src_q <= src;
      pend  <= pend_nxt;
      if (wr_mask) begin
        mask <= io_wdata[NSRC-1:0];
      end
      if (wr_ctrl) begin
        en <= io_wdata[0];
      end
      if (io_rd) begin
        io_rdata <= rd_mux;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencing FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      id    <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      id    <= id_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    id_nxt    = id;
    case (state)
      S_IDLE: begin
        if (any_elig) begin
          if (HOLDOFF == 0) begin
            state_nxt = S_FIRE;
            id_nxt    = winner;
          end else begin
            state_nxt = S_ARM;
            cnt_nxt   = 4'(HOLDOFF);
          end
        end
      end
      S_ARM: begin
        // Eligibility is looked at again on the last ARM cycle, so a source
        // masked or cleared while the prefetch settles never fires.
        if (cnt <= 4'd1) begin
          cnt_nxt = '0;
          if (any_elig) begin
            state_nxt = S_FIRE;
            id_nxt    = winner;
          end else begin
            state_nxt = S_IDLE;
          end
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      S_FIRE: begin
        state_nxt = S_SERVICE;
      end
      default: begin
        // SERVICE: only iret leaves; EN/MASK changes do not abort it.
        if (iret) begin
          state_nxt = S_IDLE;
        end
      end
    endcase
  end

  assign itr  = (state == S_FIRE);
  assign busy = (state == S_FIRE) || (state == S_SERVICE);

endmodule

// File: tb/tb_itr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_itr_ctrl
//
// Directed bench for itr_ctrl (NSRC=4, NUBITS=32, HOLDOFF=2). Drivers issue
// register accesses, source edges and iret pulses on the falling edge and
// push the expected read data / interrupt (id, cycle) into queues. Monitors
// on the falling edge pop and compare whenever the DUT returns read data or
// raises itr. Works with or without ITR_SYNC_EN defined.
// -----------------------------------------------------------------------------
module tb_itr_ctrl;

  localparam int NSRC    = 4;
  localparam int NUBITS  = 32;
  localparam int HOLDOFF = 2;
`ifdef ITR_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif
  // Falling-edge index where itr is seen, counted from the falling edge on
  // which iret (or an enabling write) is driven, or on which src_in rises.
  localparam int LAT_IRET = HOLDOFF + 2;
  localparam int LAT_SRC  = LAT_IRET + SYNC;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic              clk = 1'b0;
  logic              rst;
  logic [NSRC-1:0]   src_in;
  logic              io_wr;
  logic              io_rd;
  logic [1:0]        io_addr;
  logic [NUBITS-1:0] io_wdata;
  logic [NUBITS-1:0] io_rdata;
  logic              iret;
  logic              itr;
  logic              busy;
  logic [1:0]        id;

  always #5 clk = ~clk;

  itr_ctrl #(
    .NSRC    (NSRC),
    .NUBITS  (NUBITS),
    .HOLDOFF (HOLDOFF)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .src_in   (src_in),
    .io_wr    (io_wr),
    .io_rd    (io_rd),
    .io_addr  (io_addr),
    .io_wdata (io_wdata),
    .io_rdata (io_rdata),
    .iret     (iret),
    .itr      (itr),
    .busy     (busy),
    .id       (id)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] exp_q[$];
  logic [1:0]  exp_addr_q[$];
  logic [1:0]  exp_id_q[$];
  int          exp_cyc_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s act=%0h exp=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic rd_fired = 1'b0;
  always @(posedge clk) rd_fired <= io_rd;

  // Read-data monitor
  always @(negedge clk) begin
    logic [31:0] e;
    logic [1:0]  a;
    if (rd_fired) begin
      if (exp_q.size() == 0) begin
        chk("rd_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        a = exp_addr_q.pop_front();
        chk($sformatf("rd_addr%0d", a), io_rdata, e);
      end
    end
  end

  // Interrupt monitor: each itr-high cycle must match one queued expectation.
  always @(negedge clk) begin
    logic [1:0] ei;
    int         ec;
    if (itr === 1'b1) begin
      if (exp_id_q.size() == 0) begin
        chk("itr_unexpected", 32'(cyc), 32'hFFFF_FFFF);
      end else begin
        ei = exp_id_q.pop_front();
        ec = exp_cyc_q.pop_front();
        chk("itr_id", 32'(id), 32'(ei));
        chk("itr_cycle", 32'(cyc), 32'(ec));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    io_wr    = 1'b1;
    io_addr  = a;
    io_wdata = d;
    @(negedge clk);
    io_wr    = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp);
    io_rd   = 1'b1;
    io_addr = a;
    exp_q.push_back(exp);
    exp_addr_q.push_back(a);
    @(negedge clk);
    io_rd   = 1'b0;
  endtask

  task automatic iret_pulse();
    iret = 1'b1;
    @(negedge clk);
    iret = 1'b0;
  endtask

  task automatic expect_itr(input logic [1:0] i, input int c);
    exp_id_q.push_back(i);
    exp_cyc_q.push_back(c);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int c;
    int d;

    rst      = 1'b0;
    src_in   = 4'hF;
    io_wr    = 1'b0;
    io_rd    = 1'b0;
    io_addr  = 2'd0;
    io_wdata = '0;
    iret     = 1'b0;

    // Reset: three active cycles with all sources high.
    step(3);
    rst    = 1'b1;
    src_in = 4'h0;
    step(1);
    chk("reset_itr", 32'(itr), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_rdata", io_rdata, 32'd0);
    rd(2'd1, 32'h0);
    rd(2'd0, 32'h0);
    rd(2'd3, 32'h0);

    // Register map: unused bits read 0, PEND/ID not writable this way.
    wr(2'd0, 32'hFFFF_FFFF);
    rd(2'd0, 32'hF);
    wr(2'd3, 32'hFFFF_FFFF);
    rd(2'd3, 32'h1);
    wr(2'd1, 32'hFFFF_FFFF);
    rd(2'd1, 32'h0);
    wr(2'd2, 32'hFFFF_FFFF);
    rd(2'd2, 32'h0);
    wr(2'd0, 32'h0);
    wr(2'd3, 32'h0);
    rd(2'd0, 32'h0);

    // Single source 2; iret during ARM is ignored.
    wr(2'd0, 32'h4);
    wr(2'd3, 32'h1);
    c      = cyc;
    src_in = 4'h4;
    expect_itr(2'd2, c + LAT_SRC);
    rd(2'd1, 32'h0);
    wait_until(c + 1 + SYNC);
    rd(2'd1, 32'h4);
    iret_pulse();
    wait_until(c + LAT_SRC);
    chk("busy_fire", 32'(busy), 32'd1);
    step(1);
    src_in = 4'h0;
    rd(2'd1, 32'h0);
    rd(2'd2, 32'h2);
    chk("busy_service", 32'(busy), 32'd1);
    iret_pulse();
    chk("busy_after_iret", 32'(busy), 32'd0);

    // Priority: 1 and 3 together, 1 first, then 3; two edges on 1 during
    // the second service collapse into one more pulse.
    wr(2'd0, 32'hF);
    c      = cyc;
    src_in = 4'hA;
    expect_itr(2'd1, c + LAT_SRC);
    wait_until(c + LAT_SRC + 1);
    src_in = 4'h0;
    rd(2'd2, 32'h1);
    rd(2'd1, 32'h8);
    d = cyc;
    expect_itr(2'd3, d + LAT_IRET);
    iret_pulse();
    wait_until(d + LAT_IRET + 1);
    src_in = 4'h2;
    step(1);
    src_in = 4'h0;
    step(1);
    src_in = 4'h2;
    step(1);
    src_in = 4'h0;
    step(4);
    chk("busy_no_nest", 32'(busy), 32'd1);
    rd(2'd1, 32'h2);
    rd(2'd2, 32'h3);
    d = cyc;
    expect_itr(2'd1, d + LAT_IRET);
    iret_pulse();
    wait_until(d + LAT_IRET + 1);
    rd(2'd1, 32'h0);
    iret_pulse();
    step(8);
    chk("busy_collapse_done", 32'(busy), 32'd0);

    // Abort in ARM: MASK cleared before the last ARM cycle.
    wr(2'd0, 32'h1);
    c      = cyc;
    src_in = 4'h1;
    step(1);
    src_in = 4'h0;
    wait_until(c + 2 + SYNC);
    wr(2'd0, 32'h0);
    step(6);
    chk("busy_abort", 32'(busy), 32'd0);
    rd(2'd1, 32'h1);
    // Back in IDLE: re-enabling the mask fires source 0.
    d = cyc;
    expect_itr(2'd0, d + LAT_IRET);
    wr(2'd0, 32'h1);
    wait_until(d + LAT_IRET + 1);
    iret_pulse();
    step(2);

    // Clear race: edge on src 1 and write-1-clear land together.
    c      = cyc;
    src_in = 4'h2;
    step(1);
    src_in = 4'h0;
    step(3 + SYNC);
    rd(2'd1, 32'h2);
    c      = cyc;
    src_in = 4'h2;
    wait_until(c + SYNC);
    wr(2'd1, 32'h2);
    step(3);
    src_in = 4'h0;
    rd(2'd1, 32'h2);
    wr(2'd1, 32'h2);
    rd(2'd1, 32'h0);

    // Global enable gates firing; pending still recorded.
    wr(2'd3, 32'h0);
    wr(2'd0, 32'hF);
    src_in = 4'h8;
    step(1);
    src_in = 4'h0;
    step(6 + SYNC);
    chk("busy_en_off", 32'(busy), 32'd0);
    rd(2'd1, 32'h8);
    d = cyc;
    expect_itr(2'd3, d + LAT_IRET);
    wr(2'd3, 32'h1);
    wait_until(d + LAT_IRET + 1);
    iret_pulse();
    step(2);

    // Reset in the middle of service.
    c      = cyc;
    src_in = 4'h1;
    expect_itr(2'd0, c + LAT_SRC);
    wait_until(c + LAT_SRC + 1);
    src_in = 4'h0;
    chk("busy_pre_reset", 32'(busy), 32'd1);
    rst = 1'b0;
    step(1);
    rst = 1'b1;
    chk("busy_mid_reset", 32'(busy), 32'd0);
    step(1);
    rd(2'd3, 32'h0);
    rd(2'd1, 32'h0);
    step(8);
    chk("busy_post_reset", 32'(busy), 32'd0);

    // Every expected interrupt and read must have been seen.
    step(2);
    chk("itr_queue_left", 32'(exp_id_q.size()), 32'd0);
    chk("rd_queue_left", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
